// File: rtl/multdiv_issue.sv
// Issue/handshake controller between decode and a multi-cycle multiply/divide
// unit: latches one op, drives the unit, and returns a single writeback strobe.
module multdiv_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        issue_valid_i,
    input  logic        issue_is_mult_i,
    input  logic        issue_is_div_i,
    input  logic [31:0] issue_opA_i,
    input  logic [15:0] issue_opB_i,
    input  logic [4:0]  issue_rd_i,
    output logic [31:0] md_operandA_o,
    output logic [15:0] md_operandB_o,
    output logic        md_ctrl_MULT_o,
    output logic        md_ctrl_DIV_o,
    input  logic [31:0] md_result_i,
    input  logic        md_exception_i,
    input  logic        md_inputRDY_i,
    input  logic        md_resultRDY_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_exception_o,
    output logic        wb_timeout_o,
    output logic        illegal_op_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IN,
        BUSY,
        WB
    } state_t;

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;
    logic        wb_to_q, wb_to_d;
    logic        illegal_q, illegal_d;

    logic        legal;
    logic [6:0]  cnt_inc;
    logic        timeout;

    assign legal   = issue_valid_i & (issue_is_mult_i ^ issue_is_div_i);
    assign cnt_inc = cnt_q + 7'd1;
    // Abort once the count would reach TIMEOUT-1 on this edge
    assign timeout = (cnt_inc == CNT_LAST);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rd_q      <= '0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
            wb_to_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rd_q      <= rd_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
            wb_to_q   <= wb_to_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rd_d      = rd_q;
        mult_d    = mult_q;
        div_d     = div_q;
        wb_data_d = wb_data_q;
        wb_exc_d  = wb_exc_q;
        wb_to_d   = wb_to_q;
        illegal_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    opa_d   = issue_opA_i;
                    opb_d   = issue_opB_i;
                    rd_d    = issue_rd_i;
                    mult_d  = issue_is_mult_i;
                    div_d   = issue_is_div_i;
                    cnt_d   = '0;
                    state_d = WAIT_IN;
                end else if (issue_valid_i) begin
                    illegal_d = 1'b1;
                end
            end
            WAIT_IN: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    wb_data_d = '0;
                    wb_exc_d  = 1'b1;
                    wb_to_d   = 1'b1;
                    mult_d    = 1'b0;
                    div_d     = 1'b0;
                    state_d   = WB;
                end else if (md_inputRDY_i) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                // A result on the timeout edge still counts as a normal finish
                if (md_resultRDY_i) begin
                    wb_data_d = md_result_i;
                    wb_exc_d  = md_exception_i;
                    wb_to_d   = 1'b0;
                    mult_d    = 1'b0;
                    div_d     = 1'b0;
                    state_d   = WB;
                end else if (timeout) begin
                    wb_data_d = '0;
                    wb_exc_d  = 1'b1;
                    wb_to_d   = 1'b1;
                    mult_d    = 1'b0;
                    div_d     = 1'b0;
                    state_d   = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign md_operandA_o  = opa_q;
    assign md_operandB_o  = opb_q;
    assign md_ctrl_MULT_o = mult_q;
    assign md_ctrl_DIV_o  = div_q;
    assign stall_o        = ((state_q == IDLE) & legal)
                          | (state_q == WAIT_IN)
                          | (state_q == BUSY);
    assign wb_valid_o     = (state_q == WB);
    assign wb_rd_o        = rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_exception_o = wb_exc_q;
    assign wb_timeout_o   = wb_to_q;
    assign illegal_op_o   = illegal_q;

endmodule

// File: doc/multdiv_issue.md
MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles from operation acceptance to result before forced abort; legal range 4..127.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 issue_valid  in  1  decode presents a multiply/divide instruction.
REQ-005 issue_is_mult  in  1  presented instruction is a multiply.
REQ-006 issue_is_div  in  1  presented instruction is a divide.
REQ-007 issue_opA  in  32  first operand.
REQ-008 issue_opB  in  16  second operand.
REQ-009 issue_rd  in  5  destination register.
REQ-010 md_operandA  out  32  operand A to the multdiv unit.
REQ-011 md_operandB  out  16  operand B to the multdiv unit.
REQ-012 md_ctrl_MULT  out  1  multdiv multiply select, held for the whole operation.
REQ-013 md_ctrl_DIV  out  1  multdiv divide select, held for the whole operation.
REQ-014 md_result  in  32  multdiv result.
REQ-015 md_exception  in  1  multdiv exception.
REQ-016 md_inputRDY  in  1  multdiv ready for inputs.
REQ-017 md_resultRDY  in  1  multdiv result valid.
REQ-018 stall  out  1  freeze upstream pipeline.
REQ-019 wb_valid  out  1  one-cycle writeback strobe.
REQ-020 wb_rd  out  5  writeback destination.
REQ-021 wb_data  out  32  writeback value.
REQ-022 wb_exception  out  1  operation raised exception or timed out.
REQ-023 wb_timeout  out  1  operation aborted by timeout.
REQ-024 illegal_op  out  1  one-cycle pulse: both or neither op flag set with issue_valid.

Function
REQ-025 FSM states IDLE, WAIT_IN, BUSY, WB; only these four are reachable.
REQ-026 IDLE: issue_valid with exactly one of issue_is_mult/issue_is_div at an edge -> latch opA, opB, rd, op type; clear counter; go WAIT_IN.
REQ-027 IDLE: issue_valid with both or neither flag -> illegal_op=1 next cycle for one cycle, no latch, stay IDLE.
REQ-028 md_ctrl_MULT/md_ctrl_DIV registered; exactly the latched op's line is high in WAIT_IN and BUSY, both low in IDLE and WB; never both high.
REQ-029 md_operandA/B drive latched values, constant while either ctrl is high.
REQ-030 md_inputRDY, md_resultRDY, md_result, md_exception sampled only while a ctrl line is high (other times undriven, ignored).
REQ-031 WAIT_IN: md_inputRDY=1 at edge -> BUSY.
REQ-032 BUSY: md_resultRDY=1 at edge -> capture md_result into wb_data and md_exception into wb_exception, wb_timeout=0; go WB.
REQ-033 Counter increments every cycle in WAIT_IN and BUSY; counter reaching TIMEOUT-1 without resultRDY -> WB with wb_data=0, wb_exception=1, wb_timeout=1.
REQ-034 resultRDY and timeout on the same edge: resultRDY wins (normal capture).
REQ-035 WB: wb_valid=1 for exactly one cycle with wb_rd=latched rd; then IDLE; wb_data/wb_exception/wb_timeout hold until the next WB.
REQ-036 stall = issue_valid & legal op in IDLE, 1 in WAIT_IN and BUSY, 0 in WB; combinational from state and issue inputs.
REQ-037 Issue inputs ignored outside IDLE; the next op is accepted no earlier than the IDLE cycle after WB.
REQ-038 Minimum acceptance-to-wb_valid latency 3 cycles (inputRDY and resultRDY each on first sampled cycle).

Reset
REQ-039 reset high at an edge -> state IDLE, counter 0, all outputs 0 (md ctrl lines low, wb_valid 0, illegal_op 0, wb_data 0); dominates every other condition.
REQ-040 Reset mid-operation drops ctrl lines next cycle, emits no wb_valid; a late md_resultRDY is ignored.

Verification
REQ-041 MULT opA=7 opB=6 rd=5, inputRDY after 1 cycle, resultRDY(42) after 17 -> single wb_valid, wb_rd=5, wb_data=42, wb_exception=0, stall high until WB.
REQ-042 DIV opA=100 opB=0, resultRDY with md_exception=1 -> wb_valid, wb_exception=1, wb_timeout=0, only md_ctrl_DIV ever high.
REQ-043 issue_valid with both flags=1 -> illegal_op one-cycle pulse, ctrl lines stay 0, no wb_valid, stall 0.
REQ-044 TIMEOUT=64, resultRDY never asserted -> wb_valid exactly 64 cycles after acceptance with wb_data=0, wb_exception=1, wb_timeout=1.
REQ-045 reset asserted 5 cycles into BUSY, resultRDY 2 cycles later -> ctrl low after reset edge, no wb_valid, next MULT 3x3 completes with wb_data=9.
REQ-046 Back-to-back MULT then DIV held on issue inputs -> DIV accepted on IDLE cycle after first wb_valid; ctrl lines never overlap.
